// File: rtl/dsp_mac_pkg.sv
// rtl/dsp_mac_pkg.sv - OPMODE constants, latency and pipe stage type for the DSP MAC controller
package dsp_mac_pkg;

  localparam int P_LAT = 3;

  // X=M, Z=0 for the first product of a frame; X=M, Z=P to accumulate.
  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] OPM_IDLE  = 8'h00;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } stage_t;

endpackage

// File: rtl/dsp_mac_ctrl_if.sv
// rtl/dsp_mac_ctrl_if.sv - operand/result streams and DSP slice pins of the MAC controller
interface dsp_mac_ctrl_if #(
  parameter int CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [17:0]      in_a;
  logic [17:0]      in_b;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [47:0]      out_p;
  logic [CNT_W-1:0] out_count;

  logic [17:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_cea;
  logic             dsp_ceb;
  logic             dsp_cem;
  logic             dsp_ceopmode;
  logic             dsp_cep;
  logic             dsp_rst;
  logic [47:0]      dsp_p;

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready, dsp_p,
    output in_ready, out_valid, out_p, out_count,
    output dsp_a, dsp_b, dsp_opmode, dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep, dsp_rst
  );

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready, dsp_p,
    input  in_ready, out_valid, out_p, out_count,
    input  dsp_a, dsp_b, dsp_opmode, dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep, dsp_rst
  );

endinterface

// File: rtl/dsp_mac_vpipe.sv
// rtl/dsp_mac_vpipe.sv - valid/first/last shift register tracking pairs through the slice registers
module dsp_mac_vpipe
  import dsp_mac_pkg::*;
#(
  parameter int DEPTH = P_LAT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  stage_t                 s0,
  output stage_t [DEPTH-1:1]     stg
);

  stage_t [DEPTH-1:1] stg_q;
  stage_t [DEPTH-1:1] stg_d;

  always_comb begin
    stg_d    = stg_q;
    stg_d[1] = s0;
    for (int i = 2; i < DEPTH; i++) begin
      stg_d[i] = stg_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end

  assign stg = stg_q;

endmodule

// File: rtl/dsp_mac_ctrl.sv
// rtl/dsp_mac_ctrl.sv - drives an 18x18 DSP slice to accumulate framed operand pairs
// and holds each frame's dot product until the consumer takes it.
module dsp_mac_ctrl #(
  parameter int CNT_W = 16,
  parameter int P_LAT = 3
) (
  input  logic          CLK,
  input  logic          RST_N,
  dsp_mac_ctrl_if.slave bus
);

  import dsp_mac_pkg::*;

  stage_t               s0;
  stage_t [P_LAT-1:1]   stg;

  logic                 in_fire;
  logic                 in_ready;
  logic                 last_inflight;
  logic                 dsp_rst;
  logic                 unused_first;

  logic                 first_q, first_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cap_q, cap_d;
  logic                 out_valid_q, out_valid_d;
  logic [47:0]          out_p_q, out_p_d;
  logic [CNT_W-1:0]     out_count_q, out_count_d;
  logic [1:0]           rst_sync_q, rst_sync_d;

  // Slice sync registers stay in reset one cycle beyond RST_N release.
  assign dsp_rst = ~rst_sync_q[1];

  always_comb begin
    last_inflight = cap_q;
    for (int i = 1; i < P_LAT; i++) begin
      last_inflight = last_inflight | (stg[i].valid & stg[i].last);
    end
  end

  assign in_ready = ~dsp_rst & ~last_inflight & ~(out_valid_q & ~bus.out_ready);
  assign in_fire  = bus.in_valid & in_ready;

  assign s0.valid = in_fire;
  assign s0.first = in_fire & first_q;
  assign s0.last  = in_fire & bus.in_last;

  dsp_mac_vpipe #(
    .DEPTH (P_LAT)
  ) u_vpipe (
    .clk   (CLK),
    .rst_n (RST_N),
    .s0    (s0),
    .stg   (stg)
  );

  assign unused_first = stg[P_LAT-1].first;

  always_comb begin
    first_d     = first_q;
    cnt_d       = cnt_q;
    cap_d       = stg[P_LAT-1].valid & stg[P_LAT-1].last;
    out_valid_d = out_valid_q & ~bus.out_ready;
    out_p_d     = out_p_q;
    out_count_d = out_count_q;
    rst_sync_d  = {rst_sync_q[0], 1'b1};

    if (in_fire) begin
      first_d = bus.in_last;
      if (first_q) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // P is valid one cycle after the last product's CEP; new frames are held
    // off until here, so cnt_q still holds this frame's count.
    if (cap_q) begin
      out_valid_d = 1'b1;
      out_p_d     = bus.dsp_p;
      out_count_d = cnt_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      first_q     <= 1'b1;
      cnt_q       <= '0;
      cap_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      out_count_q <= '0;
      rst_sync_q  <= '0;
    end else begin
      first_q     <= first_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      out_count_q <= out_count_d;
      rst_sync_q  <= rst_sync_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_p        = out_p_q;
  assign bus.out_count    = out_count_q;

  assign bus.dsp_a        = bus.in_a;
  assign bus.dsp_b        = bus.in_b;
  assign bus.dsp_cea      = in_fire;
  assign bus.dsp_ceb      = in_fire;
  assign bus.dsp_cem      = stg[1].valid;
  assign bus.dsp_ceopmode = 1'b1;
  assign bus.dsp_cep      = stg[P_LAT-1].valid;
  assign bus.dsp_rst      = dsp_rst;
  assign bus.dsp_opmode   = !stg[1].valid ? OPM_IDLE :
                            stg[1].first  ? OPM_FIRST : OPM_ACC;

endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// tb/tb_dsp_mac_ctrl.sv - self-checking bench for dsp_mac_ctrl with a behavioural DSP slice
module tb_dsp_mac_ctrl;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  dsp_mac_ctrl_if #(.CNT_W(16)) bus ();

  dsp_mac_ctrl #(.CNT_W(16), .P_LAT(3)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  // Slice model: A1/B1, M, OPMODE and P registers, all with sync reset.
  logic [17:0] m_a1, m_b1;
  logic [47:0] m_m, m_p;
  logic [7:0]  m_opm;

  always @(posedge CLK) begin
    if (bus.dsp_rst) begin
      m_a1  <= '0;
      m_b1  <= '0;
      m_m   <= '0;
      m_p   <= '0;
      m_opm <= '0;
    end else begin
      if (bus.dsp_cea)      m_a1  <= bus.dsp_a;
      if (bus.dsp_ceb)      m_b1  <= bus.dsp_b;
      if (bus.dsp_cem)      m_m   <= {30'd0, m_a1} * {30'd0, m_b1};
      if (bus.dsp_ceopmode) m_opm <= bus.dsp_opmode;
      if (bus.dsp_cep)      m_p   <= ((m_opm[1:0] == 2'b01) ? m_m : 48'd0) +
                                     ((m_opm[3:2] == 2'b10) ? m_p : 48'd0);
    end
  end
  assign bus.dsp_p = m_p;

  int n_tests = 0;
  int n_fail  = 0;
  logic       pend = 1'b0;
  logic [7:0] pend_opm = 8'h00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: step to the falling edge and check the OPMODE owed by the previous accept.
  task automatic tick();
    @(negedge CLK);
    #1;
    if (pend) begin
      chk("opmode", 64'(bus.dsp_opmode), 64'(pend_opm));
      chk("cem", 64'(bus.dsp_cem), 64'd1);
      pend = 1'b0;
    end
  endtask

  task automatic send_pair(input logic [17:0] a, input logic [17:0] b, input logic last, input logic first);
    int k;
    tick();
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    #1;
    k = 0;
    while (!bus.in_ready && k < 100) begin
      tick();
      k++;
    end
    chk("accept_timeout", 64'(k < 100), 64'd1);
    chk("cea", 64'(bus.dsp_cea), 64'd1);
    chk("dsp_a", 64'(bus.dsp_a), 64'(a));
    pend     = 1'b1;
    pend_opm = first ? 8'h01 : 8'h09;
  endtask

  task automatic wait_result(input logic [47:0] exp_p, input logic [15:0] exp_cnt, input logic pulse);
    int k;
    k = 0;
    do begin
      tick();
      if (k == 0) bus.in_valid = 1'b0;
      k++;
      #1;
      if (k <= 3) chk("ready_blocked", 64'(bus.in_ready), 64'd0);
    end while (!bus.out_valid && k < 100);
    chk("latency", 64'(k), 64'd4);
    chk("out_p", 64'(bus.out_p), 64'(exp_p));
    chk("out_count", 64'(bus.out_count), 64'(exp_cnt));
    if (pulse) begin
      tick();
      chk("valid_pulse", 64'(bus.out_valid), 64'd0);
    end
  endtask

  typedef struct packed {
    logic [2:0]       n;
    logic [3:0][17:0] a;
    logic [3:0][17:0] b;
    logic [47:0]      exp_p;
    logic [15:0]      exp_cnt;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{n: 3'd4, a: {18'd7, 18'd5, 18'd3, 18'd1}, b: {18'd8, 18'd6, 18'd4, 18'd2},
                exp_p: 48'd100, exp_cnt: 16'd4};
    vecs[1] = '{n: 3'd1, a: {18'd0, 18'd0, 18'd0, 18'h3FFFF}, b: {18'd0, 18'd0, 18'd0, 18'h3FFFF},
                exp_p: 48'h0000_000F_FFF8_0001, exp_cnt: 16'd1};
    vecs[2] = '{n: 3'd3, a: {18'd0, 18'd1, 18'd1, 18'd1}, b: {18'd0, 18'd1, 18'd1, 18'd1},
                exp_p: 48'd3, exp_cnt: 16'd3};
    vecs[3] = '{n: 3'd2, a: {18'd0, 18'd0, 18'd2, 18'd2}, b: {18'd0, 18'd0, 18'd2, 18'd2},
                exp_p: 48'd8, exp_cnt: 16'd2};
    vecs[4] = '{n: 3'd2, a: {18'd0, 18'd0, 18'd3, 18'h3FFFF}, b: {18'd0, 18'd0, 18'h20000, 18'd2},
                exp_p: 48'hD_FFFE, exp_cnt: 16'd2};
    vecs[5] = '{n: 3'd1, a: {18'd0, 18'd0, 18'd0, 18'd0}, b: {18'd0, 18'd0, 18'd0, 18'd12345},
                exp_p: 48'd0, exp_cnt: 16'd1};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_dsp_rst", 64'(bus.dsp_rst), 64'd1);
    chk("rst_out_p", 64'(bus.out_p), 64'd0);
    chk("rst_out_count", 64'(bus.out_count), 64'd0);
    chk("rst_cep", 64'(bus.dsp_cep), 64'd0);
    RST_N = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b1;

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        send_pair(vecs[v].a[i], vecs[v].b[i], i == int'(vecs[v].n) - 1, i == 0);
      end
      wait_result(vecs[v].exp_p, vecs[v].exp_cnt, 1'b1);
    end

    // Mid-frame gap: P must hold while CEP is low.
    send_pair(18'd2, 18'd3, 1'b0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("gap_cep", 64'(bus.dsp_cep), 64'd0);
    chk("gap_p_hold", 64'(bus.dsp_p), 64'd6);
    send_pair(18'd4, 18'd5, 1'b1, 1'b0);
    wait_result(48'd26, 16'd2, 1'b1);

    // Back-pressure: result held, next frame blocked until it is taken.
    bus.out_ready = 1'b0;
    send_pair(18'd3, 18'd3, 1'b1, 1'b1);
    wait_result(48'd9, 16'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.in_valid = 1'b1;
      bus.in_a     = 18'd4;
      bus.in_b     = 18'd4;
      bus.in_last  = 1'b1;
      #1;
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_out_p", 64'(bus.out_p), 64'd9);
      chk("bp_out_count", 64'(bus.out_count), 64'd1);
    end
    tick();
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    pend     = 1'b1;
    pend_opm = 8'h01;
    wait_result(48'd16, 16'd1, 1'b1);

    // Reset mid-frame discards the partial frame.
    send_pair(18'd7, 18'd7, 1'b0, 1'b1);
    send_pair(18'd8, 18'd8, 1'b0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("mrst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst_out_count", 64'(bus.out_count), 64'd0);
    chk("mrst_dsp_rst", 64'(bus.dsp_rst), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_dsp_rst_hold", 64'(bus.dsp_rst), 64'd1);
    end
    RST_N = 1'b1;
    tick();
    chk("rel_dsp_rst_1", 64'(bus.dsp_rst), 64'd1);
    chk("rel_in_ready_1", 64'(bus.in_ready), 64'd0);
    tick();
    chk("rel_dsp_rst_2", 64'(bus.dsp_rst), 64'd0);
    chk("rel_in_ready_2", 64'(bus.in_ready), 64'd1);
    send_pair(18'd5, 18'd5, 1'b1, 1'b1);
    wait_result(48'd25, 16'd1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_mac_ctrl.md
Name: dsp_mac_ctrl

Overview:
- Upstream/downstream controller for the 18x18 DSP slice configured with registered operands (A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT").
- Accepts a stream of (a, b) operand pairs grouped into frames by a last flag.
- Drives the slice's A/B/OPMODE/clock-enable/reset pins so each frame is accumulated as a dot product in P.
- Captures the final P into an output holding register with valid/ready handshake.

Parameters:
- CNT_W, 16, width of the per-frame product counter and out_count.
- P_LAT, 3, cycles from operand accept to P valid; fixed to match the slice configuration above; any other value is unsupported.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller accepts pair this cycle
- in_a  in  18  multiplicand
- in_b  in  18  multiplier
- in_last  in  1  pair is last of frame
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- out_p  out  48  accumulated frame result
- out_count  out  CNT_W  products in frame, saturating at all-ones
- dsp_a  out  18  to slice A
- dsp_b  out  18  to slice B
- dsp_opmode  out  8  to slice OPMODE
- dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep  out  1 each  slice clock enables
- dsp_rst  out  1  active-high synchronous reset fanned to all slice RST pins
- dsp_p  in  48  slice P

Behaviour:
Handshake and clock enables:
- in_fire = in_valid & in_ready.
- dsp_a/dsp_b = in_a/in_b combinationally.
- dsp_cea = dsp_ceb = in_fire.
- 3-stage valid pipe: s0 = in_fire; s1 is s0 registered; s2 is s1 registered. Each stage carries first and last flags.
- first = the pair is the first accepted after reset or after a last.
- dsp_cem = s1. dsp_ceopmode = 1. dsp_cep = s2.

OPMODE generation (driven combinationally from s1):
- s1 & first: 8'b0000_0001 (X=M, Z=0, add, carry 0, no pre-adder).
- s1 & !first: 8'b0000_1001 (X=M, Z=P).
- s1 low: 8'h00. This is harmless because dsp_cep is low when it takes effect.

Result capture and flow control:
- A pair accepted at cycle t has P valid at t+3.
- When s2 & last, the controller latches dsp_p into out_p on the next edge. out_valid rises at t+4 relative to the accept of the last pair.
- out_count = number of fires in the frame, latched at the same edge. The frame counter clears after a last.
- out_valid holds until out_valid & out_ready. out_p and out_count are stable while out_valid is high.
- in_ready = !(last flag in s0, s1 or s2) & !(out_valid & !out_ready).
- A frame's last pair therefore blocks new input until its result is captured. Non-last pairs stream at one per cycle.
- An in_valid gap mid-frame is legal. CEP gating keeps P holding.

Boundary conditions:
- Single-pair frame (first & last): the result is a*b.
- Result pending and unconsumed: in_ready stays low; no pair is lost.
- out_ready already high when the result appears: out_valid pulses for one cycle; a new frame can be accepted in that cycle.
- Arithmetic is the slice's unsigned 48-bit accumulation. Wrap-around is not detected. out_count saturates.

Reset:
- RST_N low asynchronously clears pipe, flags, counter, out_valid, out_p and out_count. in_ready = 0 during reset.
- dsp_rst = 1 while RST_N low and for 1 cycle after release, via a 2-flop synchroniser. This clears the slice's sync registers. in_ready stays 0 while dsp_rst = 1.
- Reset mid-frame discards the partial frame. The next accepted pair starts a new frame.

Decomposition:
- Package dsp_mac_pkg holds OPMODE constants:
  - OPM_FIRST = 8'h01
  - OPM_ACC = 8'h09
  - OPM_IDLE = 8'h00
  - localparam P_LAT = 3
- One sub-module, dsp_mac_vpipe: the 3-stage valid/first/last shift register with async active-low reset.

Test Plan:
- Frame of 4 pairs (1,2),(3,4),(5,6),(7,8), back-to-back, out_ready=1, slice model connected -> out_p=100, out_count=4, out_valid one cycle, 4 cycles after last accept.
- Single pair (18'h3FFFF, 18'h3FFFF) with last -> out_p=48'h0000_FFFF_8000_1 (=(2^18-1)^2), out_count=1.
- Frame (2,3),gap of 3 idle cycles,(4,5) last -> out_p=26; dsp_cep low during the gap; P unchanged.
- out_ready=0 for 10 cycles after result, second frame offered -> in_ready low throughout; first result held stable; second frame result correct after release.
- Two consecutive frames (1,1)x3 then (2,2)x2 -> results 3 then 8; second frame starts with OPMODE 8'h01 (no carry-over of P).
- RST_N asserted mid-frame after 2 pairs, then frame (5,5) last -> out_p=25, out_count=1; dsp_rst high for the reset period plus 1 cycle.
